// File: rtl/ipm2l_fifo_rd_stream_if.sv
// rtl/ipm2l_fifo_rd_stream_if.sv - FIFO read port plus output stream bundle
interface ipm2l_fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rempty;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [1:0]            level;

    modport master (
        input  rempty, rd_data, m_ready,
        output r_en, m_valid, m_data, level
    );

    modport slave (
        output rempty, rd_data, m_ready,
        input  r_en, m_valid, m_data, level
    );
endinterface

// File: rtl/ipm2l_fifo_rd_stream.sv
// rtl/ipm2l_fifo_rd_stream.sv - FIFO read-latency to valid/ready stream adapter with skid buffer
module ipm2l_fifo_rd_stream #(
    parameter int c_DATA_WIDTH = 8,
    parameter int c_RD_LATENCY = 1
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    ipm2l_fifo_rd_stream_if.master bus
);
    localparam int L     = c_RD_LATENCY;
    localparam int DEPTH = L + 1;

    logic [L:1]              v;
    logic [1:0]              occ;
    logic [1:0]              level_q;
    logic [c_DATA_WIDTH-1:0] mem  [DEPTH];
    logic [c_DATA_WIDTH-1:0] nmem [DEPTH];

    logic       pop;
    logic       arr;
    logic       r_en_c;
    logic [2:0] occ_next;
    logic [2:0] pend;
    logic [2:0] sum;
    logic [1:0] wr_idx;

    always_comb begin
        pop      = (occ != 2'd0) && bus.m_ready;
        arr      = v[L];
        occ_next = 3'(occ) + 3'(arr) - 3'(pop);
        pend     = 3'd0;
        for (int i = 1; i < L; i++) begin
            pend = pend + 3'(v[i]);
        end
        sum = occ_next + pend;
        // Only issue a read if every word already committed, plus this one, has a slot.
        r_en_c = !bus.rempty && rrst_n && (sum <= 3'(L));
        wr_idx = occ - 2'(pop);
        nmem   = mem;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pop) nmem[i] = mem[i + 1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (arr && (wr_idx == 2'(i))) nmem[i] = bus.rd_data;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ     <= 2'd0;
            v       <= '0;
            level_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            occ     <= occ_next[1:0];
            v[1]    <= r_en_c;
            for (int i = 2; i <= L; i++) begin
                v[i] <= v[i - 1];
            end
            level_q <= 2'(sum + 3'(r_en_c));
            mem     <= nmem;
        end
    end

    assign bus.r_en    = r_en_c;
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = mem[0];
    assign bus.level   = level_q;
endmodule

// File: doc/ipm2l_fifo_rd_stream.md
IPM2L_FIFO_RD_STREAM -- requirements
Module: ipm2l_fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter c_DATA_WIDTH, default 8: FIFO read data and stream data width in bits.
REQ-002 The block SHALL have parameter c_RD_LATENCY, default 1: cycles from r_en high to valid rd_data; legal values 1 or 2.
REQ-003 The block SHALL have port rclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rrst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port rempty, input, 1 bit: FIFO controller read-empty flag.
REQ-006 The block SHALL have port r_en, output, 1 bit: FIFO read enable, one word per high cycle.
REQ-007 The block SHALL have port rd_data, input, c_DATA_WIDTH bits: FIFO memory read data, valid c_RD_LATENCY cycles after r_en.
REQ-008 The block SHALL have port m_valid, output, 1 bit: stream word available.
REQ-009 The block SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-010 The block SHALL have port m_data, output, c_DATA_WIDTH bits: stream word.
REQ-011 The block SHALL have port level, output, 2 bits: buffered words plus words in flight.

Function
REQ-012 The block SHALL hold an output skid buffer of c_RD_LATENCY+1 entries, where occ (0..c_RD_LATENCY+1) counts stored words.
REQ-013 The block SHALL track in-flight reads in a valid shift register v[1..c_RD_LATENCY]; v[1]<=r_en each cycle, and v[c_RD_LATENCY] marks rd_data valid this cycle.
REQ-014 The block SHALL define pop = m_valid && m_ready, and occ_next = occ + v[c_RD_LATENCY] - pop.
REQ-015 The block SHALL drive r_en combinationally: r_en = !rempty && rrst_n && (occ_next + count(v[1..c_RD_LATENCY-1]) <= c_RD_LATENCY); for c_RD_LATENCY=1 the count term is 0.
REQ-016 The block SHALL never allow an arriving word to find no free entry; overflow is a design error and carries a bench assertion.
REQ-017 The block SHALL drive m_valid = (occ != 0); m_data SHALL always be the oldest stored word (head).
REQ-018 The block SHALL keep m_data and m_valid stable while m_valid && !m_ready.
REQ-019 The block SHALL write an arrival on occ==0 into the head, which becomes visible with m_valid the next cycle.
REQ-020 On simultaneous pop and arrival, the block SHALL advance the head to the next-oldest word and append the arrival behind it; with occ==1, the arrival becomes the head.
REQ-021 The block SHALL deliver words in exact FIFO read order, with no loss or duplication.
REQ-022 The block SHALL sustain throughput of one word per cycle when rempty=0 and m_ready=1 continuously.
REQ-023 The block SHALL register level = occ + count(v); it saturates by construction at c_RD_LATENCY+1.
REQ-024 First-word latency, from rempty falling with the buffer empty to m_valid, SHALL be c_RD_LATENCY+1 cycles.
REQ-025 rempty rising SHALL stop new reads only; in-flight words SHALL still be captured and delivered.

Reset
REQ-026 While rrst_n=0, the block SHALL hold r_en=0, m_valid=0, m_data=0, level=0, occ=0, and all v bits=0, applied asynchronously.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight words; after release, the first r_en occurs on the first edge with rempty=0.

Verification
REQ-028 The bench SHALL cover: L=1, FIFO holds 4 words (A,B,C,D), m_ready=1 -> r_en high 4 consecutive cycles, m_valid from cycle 2, A..D on consecutive cycles.
REQ-029 The bench SHALL cover: L=2, 8 words, m_ready=1 -> first m_valid 3 cycles after rempty falls, then 8 back-to-back words in order.
REQ-030 The bench SHALL cover: backpressure with m_ready=0 for 5 cycles -> level reaches c_RD_LATENCY+1, r_en low, m_data frozen on head; m_ready=1 resumes 1 word/cycle with no gaps or loss.
REQ-031 The bench SHALL cover: alternating m_ready 1/0 with random rempty -> output sequence equals the FIFO contents; overflow assertion never fires.
REQ-032 The bench SHALL cover: rempty rising while 2 reads are in flight (L=2) -> both words still delivered, then m_valid=0, level=0.
REQ-033 The bench SHALL cover: rrst_n pulsed low with occ=2 -> outputs 0 immediately (asynchronously), and post-release delivery restarts from the next FIFO word.
